// File: rtl/ptw_walker.sv
// 4-level, 4 KiB-granule page-table walker between the TLB miss path and the TLB fill port.
// Define PTW_HUGEPAGE_EN to treat PTE bit 7 at lvl2/lvl1 as a 1 GiB / 2 MiB leaf.
module ptw_walker (
    input  logic        clk,
    input  logic        shutdown,
    input  logic        miss,
    input  logic [63:0] va,
    input  logic [11:0] pcid,
    input  logic [63:0] root,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_valid,
    input  logic [63:0] mem_data,
    output logic        insert,
    output logic [63:0] ins_va,
    output logic [63:0] ins_pa,
    output logic [11:0] ins_pcid,
    output logic        fault,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for a TLB miss
    // WALK   | one PTE read outstanding for level lvl
    // INSERT | one-cycle TLB fill strobe
    // FAULT  | one-cycle walk-failed strobe
    typedef enum logic [1:0] {IDLE, WALK, INSERT, FAULT} state_t;

    state_t      state, state_next;
    logic [1:0]  lvl, lvl_next;
    logic [51:12] base, base_next;
    logic [63:0] va_q, va_next;
    logic [11:0] pcid_q, pcid_next;
    logic [63:0] pa_q, pa_next;
    logic [8:0]  idx;

    always_ff @(posedge clk) begin
        if (shutdown) begin
            state  <= IDLE;
            lvl    <= 2'd0;
            base   <= '0;
            va_q   <= '0;
            pcid_q <= '0;
            pa_q   <= '0;
        end else begin
            state  <= state_next;
            lvl    <= lvl_next;
            base   <= base_next;
            va_q   <= va_next;
            pcid_q <= pcid_next;
            pa_q   <= pa_next;
        end
    end

    always_comb begin
        idx = va_q[20:12];
        case (lvl)
            2'd3:    idx = va_q[47:39];
            2'd2:    idx = va_q[38:30];
            2'd1:    idx = va_q[29:21];
            default: idx = va_q[20:12];
        endcase
    end

    always_comb begin
        state_next = state;
        lvl_next   = lvl;
        base_next  = base;
        va_next    = va_q;
        pcid_next  = pcid_q;
        pa_next    = pa_q;
        case (state)
            IDLE: begin
                if (miss) begin
                    va_next    = va;
                    pcid_next  = pcid;
                    base_next  = root[51:12];
                    lvl_next   = 2'd3;
                    state_next = WALK;
                end
            end
            WALK: begin
                if (mem_valid) begin
                    if (!mem_data[0]) begin
                        state_next = FAULT;
                    end else if (lvl == 2'd0) begin
                        pa_next    = {12'b0, mem_data[51:12], va_q[11:0]};
                        state_next = INSERT;
                    end
`ifdef PTW_HUGEPAGE_EN
                    else if (mem_data[7] && lvl == 2'd3) begin
                        state_next = FAULT;
                    end else if (mem_data[7] && lvl == 2'd2) begin
                        pa_next    = {12'b0, mem_data[51:30], va_q[29:0]};
                        state_next = INSERT;
                    end else if (mem_data[7] && lvl == 2'd1) begin
                        pa_next    = {12'b0, mem_data[51:21], va_q[20:0]};
                        state_next = INSERT;
                    end
`endif
                    else begin
                        base_next = mem_data[51:12];
                        lvl_next  = lvl - 2'd1;
                    end
                end
            end
            INSERT:  state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address is forced to zero outside WALK so the bus is quiet when idle.
    assign mem_req  = (state == WALK);
    assign mem_addr = (state == WALK) ? {12'b0, base, idx, 3'b000} : 64'd0;
    assign insert   = (state == INSERT);
    assign fault    = (state == FAULT);
    assign busy     = (state != IDLE);
    assign ins_va   = va_q;
    assign ins_pa   = pa_q;
    assign ins_pcid = pcid_q;

    logic unused_bits;
    assign unused_bits = ^{root[63:52], root[11:0], mem_data[63:52], mem_data[11:1]};

endmodule

// File: tb/tb_ptw_walker.sv
// Directed self-checking bench for ptw_walker with a table-driven memory responder
// (configurable wait states) and a passive monitor of accepts, inserts and faults.
module tb_ptw_walker;

    logic        clk = 1'b0;
    logic        shutdown;
    logic        miss;
    logic [63:0] va;
    logic [11:0] pcid;
    logic [63:0] root;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_valid;
    logic [63:0] mem_data;
    logic        insert;
    logic [63:0] ins_va;
    logic [63:0] ins_pa;
    logic [11:0] ins_pcid;
    logic        fault;
    logic        busy;

    int checks = 0;
    int failures = 0;

    ptw_walker dut (
        .clk(clk), .shutdown(shutdown), .miss(miss), .va(va), .pcid(pcid), .root(root),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .insert(insert), .ins_va(ins_va), .ins_pa(ins_pa), .ins_pcid(ins_pcid),
        .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory responder
    logic [63:0] tab_a [0:4];
    logic [63:0] tab_d [0:4];
    logic        resp_en;
    logic        force_valid;
    int          wait_cfg;
    int          wcnt = 0;

    function automatic logic [63:0] lookup(input logic [63:0] a);
        lookup = 64'd0;
        for (int i = 0; i < 5; i++)
            if (tab_a[i] == a) lookup = tab_d[i];
    endfunction

    assign mem_valid = force_valid | (resp_en && mem_req && (wcnt == wait_cfg));
    assign mem_data  = lookup(mem_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_valid) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // monitor
    int          cyc = 0;
    int          n_acc = 0, n_ins = 0, n_flt = 0, n_unstable = 0;
    int          ins_cyc = 0;
    logic [63:0] acc_q [$];
    logic [63:0] last_pa, last_va, prev_addr;
    logic [11:0] last_pcid;
    logic        prev_req = 1'b0, prev_acc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_req && mem_valid) begin
            acc_q.push_back(mem_addr);
            n_acc <= n_acc + 1;
        end
        if (mem_req && prev_req && !prev_acc && mem_addr != prev_addr) n_unstable <= n_unstable + 1;
        prev_req  <= mem_req;
        prev_acc  <= mem_valid;
        prev_addr <= mem_addr;
        if (insert) begin
            n_ins     <= n_ins + 1;
            ins_cyc   <= cyc;
            last_pa   <= ins_pa;
            last_va   <= ins_va;
            last_pcid <= ins_pcid;
        end
        if (fault) n_flt <= n_flt + 1;
    end

    task automatic set_tab(input logic [63:0] d3010);
        tab_a[0] = 64'h1000;   tab_d[0] = 64'h2003;
        tab_a[1] = 64'h2000;   tab_d[1] = 64'h3003;
        tab_a[2] = 64'h3010;   tab_d[2] = d3010;
        tab_a[3] = 64'h4008;   tab_d[3] = 64'h99003;
        tab_a[4] = 64'h600008; tab_d[4] = 64'h77003;
    endtask

    task automatic start_walk(input logic [63:0] v, input logic [11:0] p, output int start);
        va   = v;
        pcid = p;
        root = 64'h1000;
        miss = 1'b1;
        start = cyc;
    endtask

    task automatic wait_end(input int i0, input int f0, input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (n_ins != i0 || n_flt != f0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s timeout: no insert/fault seen, required one", name); end
    endtask

    task automatic test_reset;
        shutdown = 1'b1; miss = 1'b0; va = '0; pcid = '0; root = '0;
        resp_en = 1'b1; force_valid = 1'b0; wait_cfg = 0;
        set_tab(64'h4003);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, insert, fault, busy} !== 4'b0 || mem_addr !== 64'd0 || ins_va !== 64'd0 ||
            ins_pa !== 64'd0 || ins_pcid !== 12'd0) begin
            failures++;
            $display("FAIL reset: req/ins/flt/busy=%b addr=%h va=%h pa=%h pcid=%h, required all zero",
                     {mem_req, insert, fault, busy}, mem_addr, ins_va, ins_pa, ins_pcid);
        end
        shutdown = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_walk_4k;
        int start, a0, i0, f0;
        logic [63:0] exp_a [4];
        exp_a[0] = 64'h1000; exp_a[1] = 64'h2000; exp_a[2] = 64'h3010; exp_a[3] = 64'h4008;
        set_tab(64'h4003);
        a0 = n_acc; i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h5a5, start);
        wait_end(i0, f0, "walk4k");
        miss = 1'b0;
        checks++;
        if (n_acc - a0 != 4) begin failures++; $display("FAIL walk4k_nreq got %0d required 4", n_acc - a0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_q[a0 + i] !== exp_a[i]) begin
                failures++; $display("FAIL walk4k_addr%0d got %h required %h", i, acc_q[a0 + i], exp_a[i]);
            end
        end
        checks++;
        if (ins_cyc - start != 5) begin failures++; $display("FAIL walk4k_latency got %0d required 5", ins_cyc - start); end
        checks++;
        if (last_pa !== 64'h99abc || last_pcid !== 12'h5a5 || last_va !== 64'h401abc) begin
            failures++; $display("FAIL walk4k_fill pa=%h pcid=%h va=%h required 99abc 5a5 401abc", last_pa, last_pcid, last_va);
        end
        checks++;
        if (n_flt != f0) begin failures++; $display("FAIL walk4k_nofault got %0d faults required 0", n_flt - f0); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || insert !== 1'b0) begin failures++; $display("FAIL walk4k_idle busy=%b insert=%b required 0 0", busy, insert); end
    endtask

    task automatic test_not_present;
        int start, a0, i0, f0;
        set_tab(64'h0);
        a0 = n_acc; i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h0c3, start);
        wait_end(i0, f0, "notpresent");
        miss = 1'b0;
        checks++;
        if (fault !== 1'b1 || ins_va !== 64'h401abc || ins_pcid !== 12'h0c3) begin
            failures++; $display("FAIL np_fault fault=%b va=%h pcid=%h required 1 401abc 0c3", fault, ins_va, ins_pcid);
        end
        checks++;
        if (n_acc - a0 != 3) begin failures++; $display("FAIL np_nreq got %0d required 3", n_acc - a0); end
        @(negedge clk); #1;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0 || n_ins != i0 || n_flt - f0 != 1) begin
            failures++; $display("FAIL np_after fault=%b busy=%b inserts=%0d faults=%0d required 0 0 0 1",
                                 fault, busy, n_ins - i0, n_flt - f0);
        end
    endtask

    task automatic test_hugepage;
        int start, a0, i0, f0;
        set_tab(64'h600083);
        a0 = n_acc; i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h011, start);
        wait_end(i0, f0, "huge");
        miss = 1'b0;
`ifdef PTW_HUGEPAGE_EN
        checks++;
        if (n_acc - a0 != 3 || last_pa !== 64'h601abc) begin
            failures++; $display("FAIL huge_2m nreq=%0d pa=%h required 3 601abc", n_acc - a0, last_pa);
        end
`else
        checks++;
        if (n_acc - a0 != 4 || acc_q[a0 + 3] !== 64'h600008 || last_pa !== 64'h77abc) begin
            failures++; $display("FAIL huge_off nreq=%0d addr3=%h pa=%h required 4 600008 77abc",
                                 n_acc - a0, acc_q[a0 + 3], last_pa);
        end
`endif
        @(negedge clk); #1;
        // bit 7 in the top-level PTE
        set_tab(64'h4003);
        tab_d[0] = 64'h2083;
        a0 = n_acc; i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h012, start);
        wait_end(i0, f0, "huge_l3");
        miss = 1'b0;
`ifdef PTW_HUGEPAGE_EN
        checks++;
        if (n_acc - a0 != 1 || n_flt - f0 != 1) begin
            failures++; $display("FAIL huge_l3 nreq=%0d faults=%0d required 1 1", n_acc - a0, n_flt - f0);
        end
`else
        checks++;
        if (n_acc - a0 != 4 || last_pa !== 64'h99abc) begin
            failures++; $display("FAIL huge_l3_off nreq=%0d pa=%h required 4 99abc", n_acc - a0, last_pa);
        end
`endif
        @(negedge clk); #1;
    endtask

    task automatic test_wait_states;
        int start, a0, i0, f0;
        set_tab(64'h4003);
        wait_cfg = 3;
        a0 = n_acc; i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h321, start);
        wait_end(i0, f0, "wait");
        miss = 1'b0;
        checks++;
        if (ins_cyc - start != 17) begin failures++; $display("FAIL wait_latency got %0d required 17", ins_cyc - start); end
        checks++;
        if (n_unstable != 0) begin failures++; $display("FAIL wait_addr_stable got %0d changes required 0", n_unstable); end
        checks++;
        if (last_pa !== 64'h99abc || n_acc - a0 != 4) begin
            failures++; $display("FAIL wait_fill pa=%h nreq=%0d required 99abc 4", last_pa, n_acc - a0);
        end
        wait_cfg = 0;
        @(negedge clk); #1;
    endtask

    task automatic test_shutdown;
        int start, a0, i0, f0;
        bit ok = 0;
        set_tab(64'h4003);
        wait_cfg = 3;
        a0 = n_acc;
        start_walk(64'h401abc, 12'h444, start);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (n_acc != a0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL sd_first_accept timeout required one accept"); end
        miss = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        shutdown = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL sd_stop mem_req=%b busy=%b required 0 0", mem_req, busy);
        end
        shutdown = 1'b0;
        resp_en = 1'b0;
        force_valid = 1'b1;
        i0 = n_ins; f0 = n_flt;
        repeat (3) @(negedge clk);
        #1;
        force_valid = 1'b0;
        resp_en = 1'b1;
        wait_cfg = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (n_ins != i0 || n_flt != f0 || busy !== 1'b0) begin
            failures++; $display("FAIL sd_late_valid inserts=%0d faults=%0d busy=%b required 0 0 0", n_ins - i0, n_flt - f0, busy);
        end
        a0 = n_acc;
        start_walk(64'h401abc, 12'h445, start);
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
            failures++; $display("FAIL sd_restart mem_req=%b addr=%h required 1 1000", mem_req, mem_addr);
        end
        wait_end(i0, f0, "sd_rewalk");
        miss = 1'b0;
        checks++;
        if (last_pa !== 64'h99abc || n_acc - a0 != 4) begin
            failures++; $display("FAIL sd_rewalk pa=%h nreq=%0d required 99abc 4", last_pa, n_acc - a0);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_miss_while_busy;
        int start, i0, f0;
        set_tab(64'h4003);
        i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h0aa, start);
        @(negedge clk); #1;
        miss = 1'b0;
        @(negedge clk); #1;
        va = 64'h7fff_ffff_f000;
        pcid = 12'hfff;
        miss = 1'b1;
        @(negedge clk); #1;
        miss = 1'b0;
        wait_end(i0, f0, "busymiss");
        checks++;
        if (last_va !== 64'h401abc || last_pcid !== 12'h0aa || last_pa !== 64'h99abc) begin
            failures++; $display("FAIL busymiss va=%h pcid=%h pa=%h required 401abc 0aa 99abc", last_va, last_pcid, last_pa);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busymiss_idle busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back;
        int start, i0, f0;
        set_tab(64'h4003);
        i0 = n_ins; f0 = n_flt;
        start_walk(64'h401abc, 12'h101, start);
        wait_end(i0, f0, "b2b_first");
        // miss stays high through the insert edge and must not start a walk there
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL b2b_gap busy=%b mem_req=%b required 0 0", busy, mem_req);
        end
        va = 64'habcd_0000_0040_1abc;
        pcid = 12'h202;
        i0 = n_ins; f0 = n_flt;
        start = cyc;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
            failures++; $display("FAIL b2b_second_req mem_req=%b addr=%h required 1 1000", mem_req, mem_addr);
        end
        wait_end(i0, f0, "b2b_second");
        miss = 1'b0;
        checks++;
        if (last_va !== 64'habcd_0000_0040_1abc || last_pcid !== 12'h202 || last_pa !== 64'h99abc ||
            ins_cyc - start != 5) begin
            failures++; $display("FAIL b2b_second va=%h pcid=%h pa=%h lat=%0d required abcd000000401abc 202 99abc 5",
                                 last_va, last_pcid, last_pa, ins_cyc - start);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_walk_4k();
        test_not_present();
        test_hugepage();
        test_wait_states();
        test_shutdown();
        test_miss_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
